// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity checker.
package serial_parity_pkg;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    typedef enum logic {
        RX_DATA = 1'b0,
        RX_PAR  = 1'b1
    } rx_state_t;

    // acc is the XOR of all data bits; a good frame XORs to the mode value.
    function automatic logic frame_err(input logic acc, input logic pbit, input logic mode);
        return (acc ^ pbit) != mode;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// One-entry valid/ready holding register; drops a new frame and pulses overrun when full.
module frame_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_err_i,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_err_o,
    output logic              out_valid_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              load;

    // A draining buffer can accept the next frame on the same edge.
    assign load = in_valid_i & (~valid_q | out_ready_i);

    always_comb begin
        data_d    = data_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = in_valid_i & valid_q & ~out_ready_i;
        if (load) begin
            data_d  = in_data_i;
            err_d   = in_err_i;
            valid_d = 1'b1;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q    <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_err_o   = err_q;
    assign out_valid_o = valid_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserializes LSB-first frames of DATA_W data bits plus a parity bit and checks parity.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter bit          PAR_MODE = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              x_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] data_out,
    output logic              par_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam int unsigned IdxW = $clog2(DATA_W);

    rx_state_t         state_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              acc_q;
    logic              frame_done;
    logic              frame_bad;

    // sof wins over the parity slot, so a restarted frame never completes.
    assign frame_done = x_valid & ~sof & (state_q == RX_PAR);
    assign frame_bad  = frame_err(acc_q, x, PAR_MODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_DATA;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            acc_q     <= 1'b0;
        end else if (sof) begin
            state_q   <= RX_DATA;
            acc_q     <= x_valid & x;
            bit_cnt_q <= x_valid ? CntW'(1) : '0;
            if (x_valid) begin
                shift_q[0] <= x;
            end
        end else if (x_valid) begin
            case (state_q)
                RX_DATA: begin
                    shift_q[bit_cnt_q[IdxW-1:0]] <= x;
                    acc_q <= acc_q ^ x;
                    if (bit_cnt_q == CntW'(DATA_W - 1)) begin
                        bit_cnt_q <= '0;
                        state_q   <= RX_PAR;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                    end
                end
                RX_PAR: begin
                    acc_q   <= 1'b0;
                    state_q <= RX_DATA;
                end
                default: state_q <= RX_DATA;
            endcase
        end
    end

    frame_buf #(
        .DATA_W(DATA_W)
    ) u_frame_buf (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (frame_done),
        .in_data_i   (shift_q),
        .in_err_i    (frame_bad),
        .out_ready_i (out_ready),
        .out_data_o  (data_out),
        .out_err_o   (par_err),
        .out_valid_o (out_valid),
        .overrun_o   (overrun)
    );

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops them on handshakes.
module tb_serial_parity_checker;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       sof = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] data_out;
    logic       par_err;
    logic       out_valid;
    logic       overrun;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ovr_seen = 0;

    serial_parity_checker #(
        .DATA_W   (8),
        .PAR_MODE (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_valid   (x_valid),
        .sof       (sof),
        .data_out  (data_out),
        .par_err   (par_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake happens on the next edge whenever valid & ready are seen here.
    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_seen++;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", {23'd0, data_out, par_err}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_data", {24'd0, data_out}, {24'd0, e.data});
                check("frame_err", {31'd0, par_err}, {31'd0, e.err});
            end
        end
    end

    task automatic step(input logic xb, input logic xv, input logic s);
        x = xb;
        x_valid = xv;
        sof = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] d);
        for (int i = 0; i < 8; i++) step(d[i], 1'b1, 1'b0);
    endtask

    task automatic send_par(input logic pbit, input logic push, input logic [7:0] d,
                            input logic err);
        if (push) exp_q.push_back('{data: d, err: err});
        step(pbit, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step(1'b0, 1'b0, 1'b0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_par_err", {31'd0, par_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        idle(1);

        // Basic frames, back-to-back, accumulator cleared between frames
        send_bits(8'hA5);
        send_par(1'b0, 1'b1, 8'hA5, 1'b0);
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        send_bits(8'hA5);
        send_par(1'b1, 1'b1, 8'hA5, 1'b1);
        send_bits(8'h01);
        send_par(1'b1, 1'b1, 8'h01, 1'b0);
        idle(2);

        // Full buffer drops second frame with a single overrun pulse
        out_ready = 1'b0;
        send_bits(8'h3C);
        send_par(1'b0, 1'b1, 8'h3C, 1'b0);
        send_bits(8'hFF);
        send_par(1'b0, 1'b0, 8'hFF, 1'b0);
        check("ovr_pulse", {31'd0, overrun}, 32'd1);
        check("ovr_hold_data", {24'd0, data_out}, 32'h3C);
        check("ovr_hold_valid", {31'd0, out_valid}, 32'd1);
        idle(1);
        check("ovr_one_cycle", {31'd0, overrun}, 32'd0);
        check("hold_stable", {24'd0, data_out}, 32'h3C);
        out_ready = 1'b1;
        idle(1);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("retain_data", {24'd0, data_out}, 32'h3C);

        // Simultaneous drain and load
        out_ready = 1'b0;
        send_bits(8'h11);
        send_par(1'b0, 1'b1, 8'h11, 1'b0);
        send_bits(8'h22);
        out_ready = 1'b1;
        send_par(1'b0, 1'b1, 8'h22, 1'b0);
        check("swap_valid", {31'd0, out_valid}, 32'd1);
        check("swap_data", {24'd0, data_out}, 32'h22);
        check("swap_overrun", {31'd0, overrun}, 32'd0);
        idle(2);

        // sof with a bit restarts framing; partial frame discarded
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) step(i == 7, 1'b1, 1'b0);
        send_par(1'b0, 1'b1, 8'h81, 1'b0);
        idle(2);

        // sof in the parity slot drops the frame silently
        send_bits(8'h33);
        step(1'b0, 1'b0, 1'b1);
        check("sof_par_no_valid", {31'd0, out_valid}, 32'd0);
        send_bits(8'h44);
        send_par(1'b0, 1'b1, 8'h44, 1'b0);
        idle(2);

        // Gaps between bits change nothing
        begin
            logic [7:0] d;
            d = 8'h5A;
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                step(d[i], 1'b1, 1'b0);
            end
            idle(2);
            send_par(1'b0, 1'b1, 8'h5A, 1'b0);
        end
        idle(2);

        // Reset mid-frame discards buffered and partial frames
        out_ready = 1'b0;
        send_bits(8'h77);
        send_par(1'b0, 1'b0, 8'h77, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        idle(1);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {24'd0, data_out}, 32'd0);
        check("mid_rst_err", {31'd0, par_err}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        send_bits(8'h0F);
        send_par(1'b0, 1'b1, 8'h0F, 1'b0);

        begin
            int budget;
            budget = 50;
            while (exp_q.size() != 0 && budget > 0) begin
                idle(1);
                budget--;
            end
            idle(2);
        end
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("overrun_total", ovr_seen, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Downstream stage of the serial parity generator. Receives a serial bitstream framed as DATA_W data bits (LSB first) followed by one parity bit, deserializes the data word and checks parity. Presents each completed frame as a parallel word plus error flag on a one-entry valid/ready output buffer, feeding the word-level consumer.

Parameters:
DATA_W, 8, data bits per frame (>=2)
PAR_MODE, 0, 0 = even parity (XOR of data and parity bits == 0); 1 = odd parity (== 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
x  input  1  serial bit, sampled only when x_valid=1
x_valid  input  1  x carries a bit this cycle
sof  input  1  start-of-frame; restarts framing
data_out  output  DATA_W  deserialized data word
par_err  output  1  parity mismatch for the word in data_out
out_valid  output  1  data_out/par_err hold an unconsumed frame
out_ready  input  1  consumer accepts the frame when out_valid & out_ready
overrun  output  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset, with rst=1 at a clk edge: FSM=RX_DATA, bit_cnt=0, shift register=0, parity accumulator=0, data_out=0, par_err=0, out_valid=0, overrun=0. Reset mid-frame discards the partial frame and any buffered frame.
- FSM states:
  - RX_DATA: each x_valid cycle shifts x into bit position bit_cnt and sets acc ^= x. After the DATA_W-th bit, moves to RX_PAR and clears bit_cnt.
  - RX_PAR: the next x_valid bit is the parity bit. Frame error = ((acc ^ x) != PAR_MODE). Return to RX_DATA and clear acc.
- Cycles with x_valid=0 change no framing state. Gaps are allowed anywhere in the frame.
- sof=1: the current partial frame is discarded (bit_cnt=0, acc=0, FSM=RX_DATA).
  - If x_valid=1 in the same cycle, x is captured as data bit 0 of the new frame.
  - sof in the RX_PAR slot also discards the frame; no output and no overrun.
- Completion and latency: when the parity bit is sampled at edge N, out_valid=1 after edge N if the buffer can load, with data_out and par_err updated on the same edge.
- Buffer load condition: out_valid=0, OR out_valid & out_ready in the same cycle (simultaneous drain and load gives no bubble).
- Buffer full at completion (out_valid=1, out_ready=0): the new frame is dropped, the buffer is unchanged, and overrun=1 for exactly one cycle after edge N. overrun is otherwise 0.
- Handshake:
  - out_valid, data_out and par_err are stable while out_valid & !out_ready.
  - out_valid clears on a handshake edge unless a new frame loads on that edge.
  - data_out retains its last value after out_valid falls.
- Back-to-back frames with no gaps are sustained at one frame per DATA_W+1 cycles when out_ready=1.
- Widths: bit_cnt is $clog2(DATA_W+1) bits and never exceeds DATA_W-1 in RX_DATA.

Decomposition:
- Package serial_parity_pkg:
  - PAR_EVEN=0 and PAR_ODD=1 constants.
  - Enum type rx_state_t {RX_DATA, RX_PAR}.
  - Function frame_err(acc, pbit, mode).
- One sub-module is natural: frame_buf, the one-entry valid/ready holding register with the load/drain/overrun logic.
- Framing FSM and shift register stay in the top module.

Test Plan:
- DATA_W=8, PAR_MODE=0, out_ready=1: bits 1,0,1,0,0,1,0,1 then parity 0 -> one cycle later out_valid=1, data_out=0xA5, par_err=0.
- Same data bits with parity bit 1 -> data_out=0xA5, par_err=1. Next frame 0x01 with parity 1 -> par_err=0 (accumulator cleared between frames).
- out_ready=0; frames 0x3C then 0xFF sent back-to-back -> data_out stays 0x3C, overrun pulses once for 1 cycle at 0xFF completion. Then out_ready=1 -> 0x3C consumed, out_valid=0.
- Buffer holds 0x11; out_ready=1 in exactly the cycle the parity bit of 0x22 arrives -> 0x11 handshakes, data_out=0x22, out_valid stays 1, overrun=0.
- 3 data bits sent, then sof=1 with x_valid=1 and x=1, followed by 7 more bits forming 0x81 and parity 0 -> data_out=0x81, par_err=0; the partial frame is never output.
- Random x_valid gaps within a frame of 0x5A -> same result as the gapless case. rst=1 mid-frame, then a full frame 0x0F -> only 0x0F appears, and all outputs read 0 during reset.
